alu_mdu_controller: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder. It decodes instruction class, func3 and the full func7 into the 4-bit ALU op code, with corrected I-type decoding and explicit codes for LUI and branch. It also adds an iterative RV32M multiply/divide sequencer with a stall handshake, so the single-cycle datapath can support M-extension ops by freezing the PC and register write until the result is ready.

---
 rtl/alu_mdu_controller_if.sv | 36 +++
 rtl/alu_mdu_controller.sv | 216 +++++++++++++++++++++
 tb/tb_alu_mdu_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_controller_if.sv
// Decoder/datapath bundle for the ALU op decoder and the RV32M sequencer.
interface alu_mdu_controller_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic            r_type;
    logic            i_type;
    logic            store;
    logic            load;
    logic            branch;
    logic            jal;
    logic            lui;
    logic            auipc;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [3:0]      alu_controller;
    logic            m_busy;
    logic            m_done;
    logic [XLEN-1:0] m_result;

    modport master (
        output valid_in, r_type, i_type, store, load,
        output branch, jal, lui, auipc,
        output func3, func7, op_a, op_b,
        input  alu_controller, m_busy, m_done, m_result
    );

    modport slave (
        input  valid_in, r_type, i_type, store, load,
        input  branch, jal, lui, auipc,
        input  func3, func7, op_a, op_b,
        output alu_controller, m_busy, m_done, m_result
    );
endinterface

// File: rtl/alu_mdu_controller.sv
// ALU op decoder plus iterative RV32M multiply/divide sequencer with stall.
// Optional MDU_EARLY_OUT_EN: zero-operand MUL and |a|<|b| DIV finish in one cycle.
module alu_mdu_controller #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic                 clk,
    input logic                 rst,
    alu_mdu_controller_if.slave bus
);
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b1001;
    localparam logic [3:0] ALU_PASS = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    logic [3:0] base_op;
    logic [3:0] alu_c;
    logic [2:0] f3;
    logic [6:0] f7;

    assign f3 = bus.func3;
    assign f7 = bus.func7;

    always_comb begin
        base_op = ALU_ADD;
        unique case (f3)
            3'b000: base_op = ALU_ADD;
            3'b001: base_op = ALU_SLL;
            3'b010: base_op = ALU_SLT;
            3'b011: base_op = ALU_SLTU;
            3'b100: base_op = ALU_XOR;
            3'b101: base_op = ALU_SRL;
            3'b110: base_op = ALU_OR;
            3'b111: base_op = ALU_AND;
        endcase
    end

    // Class flags should be one-hot; the case order resolves overlaps.
    always_comb begin
        alu_c = ALU_ADD;
        priority case (1'b1)
            bus.r_type: begin
                if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
                    alu_c = base_op;
                    if (f3 == 3'b000 && f7[5]) alu_c = ALU_SUB;
                    if (f3 == 3'b101 && f7[5]) alu_c = ALU_SRA;
                end
            end
            bus.i_type: begin
                alu_c = base_op;
                if (f3 == 3'b101 && f7[5]) alu_c = ALU_SRA;
            end
            bus.store:  alu_c = ALU_ADD;
            bus.load:   alu_c = ALU_ADD;
            bus.branch: alu_c = ALU_SUB;
            bus.jal:    alu_c = ALU_ADD;
            bus.lui:    alu_c = ALU_PASS;
            bus.auipc:  alu_c = ALU_ADD;
            default:    alu_c = ALU_ADD;
        endcase
    end

    assign bus.alu_controller = alu_c;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [2*XLEN-1:0]   acc, acc_n;
    logic [XLEN-1:0]     mcand_q, mcand_n;
    logic [2:0]          f3_q, f3_n;
    logic                neg_q, neg_qn;
    logic                neg_r, neg_rn;
    logic [XLEN-1:0]     res_q, res_n;
    logic                busy, done;

    logic                m_op;
    logic                a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf, early, short_path;
    logic [XLEN-1:0]     short_res;

    assign m_op  = bus.valid_in & bus.r_type & (f7 == 7'b0000001);
    assign a_sgn = (f3 == 3'b001) | (f3 == 3'b010) | (f3 == 3'b100) | (f3 == 3'b110);
    assign b_sgn = (f3 == 3'b001) | (f3 == 3'b100) | (f3 == 3'b110);
    assign a_neg = a_sgn & bus.op_a[XLEN-1];
    assign b_neg = b_sgn & bus.op_b[XLEN-1];
    assign mag_a = a_neg ? -bus.op_a : bus.op_a;
    assign mag_b = b_neg ? -bus.op_b : bus.op_b;

    assign div_zero = bus.op_b == '0;
    assign div_ovf  = ~f3[0]
                    & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                    & (bus.op_b == '1);

`ifdef MDU_EARLY_OUT_EN
    assign early = f3[2] ? (mag_a < mag_b)
                         : (bus.op_a == '0 || bus.op_b == '0);
`else
    assign early = 1'b0;
`endif

    assign short_path = f3[2] ? (div_zero | div_ovf | early) : early;

    always_comb begin
        short_res = '0;
        if (f3[2]) begin
            if (div_zero)     short_res = f3[1] ? bus.op_a : '1;
            else if (div_ovf) short_res = f3[1] ? '0 : bus.op_a;
            else if (f3[1])   short_res = bus.op_a;
        end
    end

    // acc holds {partial, multiplier} for MUL and {remainder, quotient} for DIV.
    logic [XLEN:0]     sum, shifted, diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quo, rem, fin_res;

    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        mul_next = acc[0] ? {sum, acc[XLEN-1:1]}
                          : {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};
        shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff     = shifted - {1'b0, mcand_q};
        div_next = diff[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod     = neg_q ? -mul_next : mul_next;
        quo      = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        rem      = neg_r ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        fin_res  = prod[XLEN-1:0];
        unique case (f3_q)
            3'b000:                 fin_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_res = quo;
            3'b110, 3'b111:         fin_res = rem;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        mcand_n = mcand_q;
        f3_n    = f3_q;
        neg_qn  = neg_q;
        neg_rn  = neg_r;
        res_n   = res_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (m_op) begin
                    busy    = 1'b1;
                    f3_n    = f3;
                    neg_qn  = a_neg ^ b_neg;
                    neg_rn  = a_neg;
                    mcand_n = mag_b;
                    acc_n   = {{XLEN{1'b0}}, mag_a};
                    if (short_path) begin
                        res_n   = short_res;
                        state_n = S_DONE;
                    end else begin
                        cnt_n   = CNT_W'(XLEN);
                        state_n = f3[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                busy  = 1'b1;
                acc_n = (state == S_MUL) ? mul_next : div_next;
                cnt_n = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    res_n   = fin_res;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand_q <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            res_q   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            acc     <= acc_n;
            mcand_q <= mcand_n;
            f3_q    <= f3_n;
            neg_q   <= neg_qn;
            neg_r   <= neg_rn;
            res_q   <= res_n;
        end
    end

    assign bus.m_busy   = busy & ~rst;
    assign bus.m_done   = done & ~rst;
    assign bus.m_result = res_q;
endmodule

// File: tb/tb_alu_mdu_controller.sv
// Directed bench for alu_mdu_controller: decode table, M-ops with a
// result scoreboard, short paths, back-to-back issue and mid-op reset.
module tb_alu_mdu_controller;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_mdu_controller_if #(.XLEN(32)) bus ();

    alu_mdu_controller #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] cls;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] exp;
        string      tag;
    } dec_t;

    dec_t dec_tab[21] = '{
        '{8'h80, 3'b000, 7'h20, 4'h9, "r_sub"},
        '{8'h80, 3'b101, 7'h20, 4'h6, "r_sra"},
        '{8'h80, 3'b001, 7'h00, 4'h1, "r_sll"},
        '{8'h80, 3'b111, 7'h00, 4'h8, "r_and"},
        '{8'h80, 3'b001, 7'h20, 4'h1, "r_sll_f7b"},
        '{8'h80, 3'b000, 7'h01, 4'h0, "r_mop"},
        '{8'h80, 3'b010, 7'h02, 4'h0, "r_bad_f7"},
        '{8'h40, 3'b000, 7'h20, 4'h0, "i_add_f7"},
        '{8'h40, 3'b101, 7'h20, 4'h6, "i_sra"},
        '{8'h40, 3'b101, 7'h00, 4'h5, "i_srl"},
        '{8'h40, 3'b011, 7'h7f, 4'h3, "i_sltu"},
        '{8'h40, 3'b001, 7'h00, 4'h1, "i_sll"},
        '{8'h02, 3'b000, 7'h00, 4'ha, "lui"},
        '{8'h08, 3'b000, 7'h00, 4'h9, "branch"},
        '{8'h20, 3'b010, 7'h00, 4'h0, "store"},
        '{8'h10, 3'b010, 7'h00, 4'h0, "load"},
        '{8'h04, 3'b000, 7'h00, 4'h0, "jal"},
        '{8'h01, 3'b000, 7'h00, 4'h0, "auipc"},
        '{8'h00, 3'b110, 7'h00, 4'h0, "none"},
        '{8'h82, 3'b100, 7'h00, 4'h4, "prio_r_lui"},
        '{8'h0a, 3'b000, 7'h00, 4'h9, "prio_br_lui"}
    };

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cls(input logic [7:0] cls);
        {bus.r_type, bus.i_type, bus.store, bus.load,
         bus.branch, bus.jal, bus.lui, bus.auipc} = cls;
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk($sformatf("%s sb_empty", tag), 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s result", tag), bus.m_result, e);
        end
    endtask

    task automatic run_mop(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat);
        bit seen;
        @(negedge clk); #1;
        bus.valid_in = 1'b1;
        set_cls(8'h80);
        bus.func7 = 7'b0000001;
        bus.func3 = f3;
        bus.op_a  = a;
        bus.op_b  = b;
        exp_q.push_back(exp);
        #1;
        chk($sformatf("%s busy0", tag), 32'(bus.m_busy), 32'd1);
        chk($sformatf("%s aluc", tag), 32'(bus.alu_controller), 32'd0);
        seen = 1'b0;
        for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
            @(negedge clk); #1;
            if (bus.m_done === 1'b1) begin
                seen = 1'b1;
                chk($sformatf("%s lat", tag), 32'(cyc), 32'(lat));
                chk($sformatf("%s busy_done", tag), 32'(bus.m_busy), 32'd0);
                pop_chk(tag);
            end else begin
                chk($sformatf("%s busy%0d", tag, cyc), 32'(bus.m_busy), 32'd1);
            end
            if (cyc == 1) begin
                bus.valid_in = 1'b0;
                bus.op_a  = $urandom;
                bus.op_b  = $urandom;
                bus.func3 = 3'($urandom_range(0, 7));
            end
        end
        chk($sformatf("%s done_seen", tag), 32'(seen), 32'd1);
        @(negedge clk); #1;
        chk($sformatf("%s pulse", tag), 32'(bus.m_done), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        rst = 1'b1;
        bus.valid_in = 1'b0;
        set_cls(8'h00);
        bus.func3 = 3'b000;
        bus.func7 = 7'b0000000;
        bus.op_a  = '0;
        bus.op_b  = '0;

        @(negedge clk); #1;
        bus.valid_in = 1'b1;
        set_cls(8'h80);
        bus.func7 = 7'b0000001;
        bus.func3 = 3'b100;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd3;
        #1;
        chk("rst busy", 32'(bus.m_busy), 32'd0);
        @(negedge clk); #1;
        chk("rst done", 32'(bus.m_done), 32'd0);
        chk("rst result", bus.m_result, 32'd0);
        bus.valid_in = 1'b0;
        rst = 1'b0;

        foreach (dec_tab[k]) begin
            @(negedge clk); #1;
            set_cls(dec_tab[k].cls);
            bus.func3 = dec_tab[k].f3;
            bus.func7 = dec_tab[k].f7;
            #1;
            chk(dec_tab[k].tag, 32'(bus.alu_controller), 32'(dec_tab[k].exp));
        end

        run_mop("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_mop("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_mop("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_mop("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33);
        run_mop("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_mop("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_mop("divu",   3'b101, 32'd100,      32'd7,        32'd14,        33);
        run_mop("remu",   3'b111, 32'd100,      32'd7,        32'd2,         33);
        run_mop("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_mop("rem0",   3'b110, 32'd5,        32'd0,        32'd5,         1);
        run_mop("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_mop("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

        @(negedge clk); #1;
        bus.valid_in = 1'b1;
        set_cls(8'h80);
        bus.func7 = 7'b0000001;
        bus.func3 = 3'b101;
        bus.op_a  = 32'd5;
        bus.op_b  = 32'd0;
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFF);
        #1;
        chk("b2b busy0", 32'(bus.m_busy), 32'd1);
        @(negedge clk); #1;
        chk("b2b done1", 32'(bus.m_done), 32'd1);
        chk("b2b busy1", 32'(bus.m_busy), 32'd0);
        pop_chk("b2b first");
        @(negedge clk); #1;
        chk("b2b busy2", 32'(bus.m_busy), 32'd1);
        chk("b2b done2", 32'(bus.m_done), 32'd0);
        @(negedge clk); #1;
        chk("b2b done3", 32'(bus.m_done), 32'd1);
        pop_chk("b2b second");
        bus.valid_in = 1'b0;

        @(negedge clk); #1;
        bus.valid_in = 1'b1;
        bus.func3 = 3'b101;
        bus.op_a  = 32'd100;
        bus.op_b  = 32'd7;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk); #1;
            bus.valid_in = 1'b0;
        end
        chk("rstmid busy_before", 32'(bus.m_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid busy_forced", 32'(bus.m_busy), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstmid result", bus.m_result, 32'd0);
        n_done = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk); #1;
            if (bus.m_done === 1'b1) n_done++;
        end
        chk("rstmid no_done", 32'(n_done), 32'd0);
        chk("rstmid idle_busy", 32'(bus.m_busy), 32'd0);
        chk("sb drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
